cpu_front_stages: RTL and testbench
===================================

# cpu_front_stages

Front half of the five-stage 64-bit LEGv8-subset pipeline: instruction fetch (IF), decode/register read/branch resolution (ID) and execute (EX). It owns the PC, the 32×64 register file, the condition-flag register and the ALU. It drives the external instruction memory and hands a registered EX/MEM bundle to the memory stage. Register writes arrive back from the write-back stage.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `instr_addr`  out  64  byte address of the instruction being fetched (= PC).
- `instr`  in  32  instruction word at `instr_addr`, combinational return.
- `wb_en`  in  1  register-file write enable from write-back.
- `wb_reg`  in  5  write-back destination register.
- `wb_data`  in  64  write-back data.
- `ex_result`  out  64  registered ALU result, load/store address, or BL link value.
- `ex_store_data`  out  64  registered Rt value for STUR.
- `ex_rd`  out  5  registered destination register.
- `ex_reg_write`  out  1  registered: the instruction writes a register.
- `ex_mem_read`  out  1  registered: LDUR, so memory data selects the write-back value.
- `ex_mem_write`  out  1  registered: STUR.

## Operation
Decoded instructions, with bit fields given as [msb:lsb]. Any other encoding is a NOP with no writes and no flag update.
- ADDI, [31:22]=1001000100: Rd = Rn + zext(imm12[21:10]).
- ADDS / SUBS, [31:21]=10101011000 / 11101011000: Rd = Rn ± Rm[20:16]; updates flags.
- LDUR / STUR, [31:21]=11111000010 / 11111000000: address = Rn + sext(imm9[20:12]). Rt is [4:0]. Access size is 8 bytes.
- B / BL, [31:26]=000101 / 100101: target = PC_id + (sext(imm26)<<2). BL also writes X30 = PC_id + 4.
- BR, [31:21]=11010110000: target = value of Rn.
- CBZ, [31:24]=10110100: if Rt==0 then target = PC_id + (sext(imm19[23:5])<<2).
- B.LT, [31:24]=01010100 with [4:0]=01011: taken when N≠V. Any other cond value is a NOP.

Register file:
- X31 always reads 0; writes to X31 are ignored.
- Write-through bypass: in the cycle where `wb_en` is high and `wb_reg` equals a read port's register (and is not 31), that port returns `wb_data`.

ALU and flags:
- All arithmetic is 64-bit two's complement.
- SUBS computes A + ~B + 1.
- N = result[63]; Z = (result==0); C = carry out of bit 63; V = signed overflow.
- The flag register updates only when ADDS/SUBS is in EX.

Branches:
- Branches resolve in ID and have exactly one delay slot. The instruction already fetched behind a branch always executes.
- B.LT in ID uses the combinational flags of an ADDS/SUBS currently in EX if one is present; otherwise it uses the flag register.
- No other forwarding or interlocking exists. Software must place at least 2 instructions between a producer and an ID-stage consumer; the write-back bypass covers the rest.

## Timing
- Reset (asynchronous):
  - PC = 0, so `instr_addr` = 0.
  - IF/ID and ID/EX registers hold a NOP.
  - All `ex_*` outputs = 0.
  - Flags NZCV = 0. Register-file contents = 0.
- Reset asserted mid-run squashes every in-flight instruction. Fetch restarts at address 0 on the first edge after deassertion.
- Next PC = branch target when ID resolves a taken branch, else PC + 4.
- An instruction presented on `instr` in cycle c is in ID in c+1, in EX in c+2, and appears on the `ex_*` outputs in c+3.
- A taken branch fetched in cycle c:
  - its delay-slot instruction is fetched in c+1;
  - `instr_addr` equals the target in c+2.
- Register writes take effect at the edge. Same-cycle reads see them through the bypass.

## Test plan
- Reset: assert `reset` for 1.5 cycles → `instr_addr`=0 and all `ex_*`=0 during reset. After release, `instr_addr` steps 0, 4, 8.
- ADDI X1,X31,#5 at address 0 → in cycle 3: `ex_result`=5, `ex_rd`=1, `ex_reg_write`=1. Then feed back `wb_en`=1, `wb_reg`=1, `wb_data`=5.
- SUBS X2,X1,X1 with X1=5, followed 2 slots later by B.LT +8 → Z=1, V=N=0, branch not taken, PC advances by 4. Same test with X1−X3 where X1=3, X3=5 → N=1, B.LT taken.
- B +16 at address 8 → `instr_addr` sequence 8, 12 (delay slot executes), 24.
- BL at address 0x20 with imm26=4 → X30 link `ex_result`=0x24, `ex_rd`=30. Then BR X30 → fetch returns to 0x24 after the delay slot.
- STUR X1,[X31,#-8] with X1=5 → `ex_result`=0xFFFF_FFFF_FFFF_FFF8, `ex_store_data`=5, `ex_mem_write`=1, `ex_reg_write`=0. CBZ X31 is always taken.

Source files
------------

// File: rtl/cpu_front_stages.sv
// cpu_front_stages: IF, ID and EX of a five-stage 64-bit LEGv8-subset pipeline.
// Branches resolve in ID with one delay slot; EX/MEM bundle is registered out.
module cpu_front_stages (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] instr_addr,
    input  logic [31:0] instr,
    input  logic        wb_en,
    input  logic [4:0]  wb_reg,
    input  logic [63:0] wb_data,
    output logic [63:0] ex_result,
    output logic [63:0] ex_store_data,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
    } if_id_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic [63:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        set_flags;
    } id_ex_t;

    typedef struct packed {
        logic [63:0] result;
        logic [63:0] store_data;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } ex_mem_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

    logic [63:0] pc_q, pc_d;
    if_id_t      ifid_q, ifid_d;
    id_ex_t      idex_q, idex_d;
    ex_mem_t     exmem_q, exmem_d;
    flags_t      flags_q, flags_d;
    logic [63:0] rf_q [32];
    logic [63:0] rf_d [32];

    logic [31:0] ir;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [4:0]  rt;
    logic [4:0]  rb_idx;
    logic [63:0] ra;
    logic [63:0] rb;
    logic [63:0] imm12;
    logic [63:0] imm9;
    logic [63:0] off26;
    logic [63:0] off19;

    logic is_addi;
    logic is_adds;
    logic is_subs;
    logic is_ldur;
    logic is_stur;
    logic is_b;
    logic is_bl;
    logic is_br;
    logic is_cbz;
    logic is_blt;

    logic        br_taken;
    logic [63:0] br_target;
    logic        lt_flag;

    logic [63:0] alu_b;
    logic [64:0] alu_sum;
    logic        alu_n;
    logic        alu_z;
    logic        alu_c;
    logic        alu_v;

    // Z and C are architected state, but no decoded branch consumes them.
    logic flags_unused;
    assign flags_unused = flags_q.z ^ flags_q.c;

    assign instr_addr = pc_q;

    assign ir = ifid_q.instr;
    assign rn = ir[9:5];
    assign rm = ir[20:16];
    assign rt = ir[4:0];

    assign imm12 = {52'd0, ir[21:10]};
    assign imm9  = {{55{ir[20]}}, ir[20:12]};
    assign off26 = {{36{ir[25]}}, ir[25:0], 2'b00};
    assign off19 = {{43{ir[23]}}, ir[23:5], 2'b00};

    always_comb begin
        is_addi = (ir[31:22] == 10'b1001000100);
        is_adds = (ir[31:21] == 11'b10101011000);
        is_subs = (ir[31:21] == 11'b11101011000);
        is_ldur = (ir[31:21] == 11'b11111000010);
        is_stur = (ir[31:21] == 11'b11111000000);
        is_b    = (ir[31:26] == 6'b000101);
        is_bl   = (ir[31:26] == 6'b100101);
        is_br   = (ir[31:21] == 11'b11010110000);
        is_cbz  = (ir[31:24] == 8'b10110100);
        is_blt  = (ir[31:24] == 8'b01010100) && (rt == 5'b01011);
    end

    assign rb_idx = (is_adds || is_subs) ? rm : rt;

    // Read ports see a same-cycle write-back; X31 is hard zero.
    always_comb begin
        ra = rf_q[rn];
        if (wb_en && (wb_reg == rn)) begin
            ra = wb_data;
        end
        if (rn == 5'd31) begin
            ra = '0;
        end
        rb = rf_q[rb_idx];
        if (wb_en && (wb_reg == rb_idx)) begin
            rb = wb_data;
        end
        if (rb_idx == 5'd31) begin
            rb = '0;
        end
    end

    always_comb begin
        alu_b   = idex_q.sub ? ~idex_q.b : idex_q.b;
        alu_sum = {1'b0, idex_q.a} + {1'b0, alu_b} + {64'd0, idex_q.sub};
        alu_n   = alu_sum[63];
        alu_z   = (alu_sum[63:0] == 64'd0);
        alu_c   = alu_sum[64];
        alu_v   = (idex_q.a[63] == alu_b[63]) && (alu_sum[63] != idex_q.a[63]);
    end

    // A flag setter in EX is newer than the flag register.
    assign lt_flag = idex_q.set_flags ? (alu_n ^ alu_v)
                                      : (flags_q.n ^ flags_q.v);

    always_comb begin
        idex_d    = '0;
        br_taken  = 1'b0;
        br_target = '0;
        unique case (1'b1)
            is_addi: begin
                idex_d.a         = ra;
                idex_d.b         = imm12;
                idex_d.rd        = rt;
                idex_d.reg_write = 1'b1;
            end
            is_adds, is_subs: begin
                idex_d.a         = ra;
                idex_d.b         = rb;
                idex_d.sub       = is_subs;
                idex_d.rd        = rt;
                idex_d.reg_write = 1'b1;
                idex_d.set_flags = 1'b1;
            end
            is_ldur: begin
                idex_d.a         = ra;
                idex_d.b         = imm9;
                idex_d.rd        = rt;
                idex_d.reg_write = 1'b1;
                idex_d.mem_read  = 1'b1;
            end
            is_stur: begin
                idex_d.a          = ra;
                idex_d.b          = imm9;
                idex_d.store_data = rb;
                idex_d.mem_write  = 1'b1;
            end
            is_b: begin
                br_taken  = 1'b1;
                br_target = ifid_q.pc + off26;
            end
            is_bl: begin
                br_taken         = 1'b1;
                br_target        = ifid_q.pc + off26;
                idex_d.a         = ifid_q.pc;
                idex_d.b         = 64'd4;
                idex_d.rd        = 5'd30;
                idex_d.reg_write = 1'b1;
            end
            is_br: begin
                br_taken  = 1'b1;
                br_target = ra;
            end
            is_cbz: begin
                br_taken  = (rb == 64'd0);
                br_target = ifid_q.pc + off19;
            end
            is_blt: begin
                br_taken  = lt_flag;
                br_target = ifid_q.pc + off19;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        pc_d         = br_taken ? br_target : pc_q + 64'd4;
        ifid_d.instr = instr;
        ifid_d.pc    = pc_q;
    end

    always_comb begin
        exmem_d.result     = alu_sum[63:0];
        exmem_d.store_data = idex_q.store_data;
        exmem_d.rd         = idex_q.rd;
        exmem_d.reg_write  = idex_q.reg_write;
        exmem_d.mem_read   = idex_q.mem_read;
        exmem_d.mem_write  = idex_q.mem_write;
        flags_d            = flags_q;
        if (idex_q.set_flags) begin
            flags_d = '{n: alu_n, z: alu_z, c: alu_c, v: alu_v};
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_reg != 5'd31)) begin
            rf_d[wb_reg] = wb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            flags_q <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            flags_q <= flags_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            rf_q <= rf_d;
        end
    end

    assign ex_result     = exmem_q.result;
    assign ex_store_data = exmem_q.store_data;
    assign ex_rd         = exmem_q.rd;
    assign ex_reg_write  = exmem_q.reg_write;
    assign ex_mem_read   = exmem_q.mem_read;
    assign ex_mem_write  = exmem_q.mem_write;

endmodule

// File: tb/tb_cpu_front_stages.sv
// Directed bench for cpu_front_stages with a small instruction ROM
// and a one-cycle MEM stage feeding register write-back.
module tb_cpu_front_stages;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] instr_addr;
    logic [31:0] instr = 32'd0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_reg = 5'd0;
    logic [63:0] wb_data = 64'd0;
    logic [63:0] ex_result;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [31:0] imem [64];
    logic [71:0] ex_v;
    logic [71:0] exp_v;

    assign ex_v = {ex_result, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write};

    cpu_front_stages dut (
        .clk           (clk),
        .reset         (reset),
        .instr_addr    (instr_addr),
        .instr         (instr),
        .wb_en         (wb_en),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .ex_result     (ex_result),
        .ex_store_data (ex_store_data),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] e_addi(int rd, int rn, int imm);
        return {10'b1001000100, imm[11:0], rn[4:0], rd[4:0]};
    endfunction

    function automatic logic [31:0] e_rr(bit sub, int rd, int rn, int rm);
        return {(sub ? 11'b11101011000 : 11'b10101011000), rm[4:0], 6'd0, rn[4:0], rd[4:0]};
    endfunction

    function automatic logic [31:0] e_mem(bit ld, int rt, int rn, int imm);
        return {(ld ? 11'b11111000010 : 11'b11111000000), imm[8:0], 2'b00, rn[4:0], rt[4:0]};
    endfunction

    function automatic logic [31:0] e_b(bit link, int imm);
        return {(link ? 6'b100101 : 6'b000101), imm[25:0]};
    endfunction

    function automatic logic [31:0] e_br(int rn);
        return {11'b11010110000, 5'b11111, 6'd0, rn[4:0], 5'd0};
    endfunction

    function automatic logic [31:0] e_cbz(int rt, int imm);
        return {8'b10110100, imm[18:0], rt[4:0]};
    endfunction

    function automatic logic [31:0] e_blt(int imm);
        return {8'b01010100, imm[18:0], 5'b01011};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) imem[i] = 32'd0;
    endtask

    // One clock: MEM/WB model forwards last cycle's EX bundle (no load data).
    task automatic tick();
        logic        s_rw;
        logic        s_mr;
        logic [4:0]  s_rd;
        logic [63:0] s_res;
        s_rw  = ex_reg_write;
        s_mr  = ex_mem_read;
        s_rd  = ex_rd;
        s_res = ex_result;
        @(posedge clk);
        #1;
        wb_en   = s_rw && !s_mr;
        wb_reg  = s_rd;
        wb_data = s_res;
        instr   = imem[instr_addr[7:2]];
        cyc++;
    endtask

    task automatic run_to(int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset   = 1'b1;
        wb_en   = 1'b0;
        wb_reg  = 5'd0;
        wb_data = 64'd0;
        #1;
        if (instr_addr !== 64'd0) begin
            $display("FAIL rst_addr got=%h want=0", instr_addr);
            bad++;
        end
        total++;
        if ({ex_v, ex_store_data} !== 136'd0) begin
            $display("FAIL rst_ex got=%h/%h want=0", ex_v, ex_store_data);
            bad++;
        end
        total++;
        #13;
        reset = 1'b0;
        cyc   = 0;
        instr = imem[0];
    endtask

    task automatic test_reset();
        clear_prog();
        do_reset();
        if (instr_addr !== 64'd0) begin
            $display("FAIL step0 got=%h want=0", instr_addr);
            bad++;
        end
        total++;
        tick();
        if (instr_addr !== 64'd4) begin
            $display("FAIL step1 got=%h want=4", instr_addr);
            bad++;
        end
        total++;
        tick();
        if (instr_addr !== 64'd8) begin
            $display("FAIL step2 got=%h want=8", instr_addr);
            bad++;
        end
        total++;
    endtask

    task automatic test_addi();
        clear_prog();
        imem[0] = e_addi(1, 31, 5);
        imem[1] = e_addi(31, 31, 9);
        imem[4] = e_rr(1'b0, 2, 31, 1);
        do_reset();
        run_to(3);
        exp_v = {64'd5, 5'd1, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL addi_x1 got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(4);
        exp_v = {64'd9, 5'd31, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL addi_x31 got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(7);
        exp_v = {64'd5, 5'd2, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL adds_x31 got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
    endtask

    task automatic test_flags();
        clear_prog();
        imem[0]  = e_addi(1, 31, 5);
        imem[1]  = e_addi(3, 31, 3);
        imem[3]  = e_rr(1'b1, 2, 1, 1);
        imem[6]  = e_blt(2);
        imem[8]  = e_rr(1'b1, 4, 3, 1);
        imem[9]  = e_blt(4);
        imem[10] = e_addi(5, 31, 7);
        imem[11] = e_addi(7, 31, 1);
        imem[12] = e_addi(7, 31, 1);
        imem[13] = e_addi(6, 31, 9);
        do_reset();
        run_to(6);
        exp_v = {64'd0, 5'd2, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL subs_zero got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(8);
        if (instr_addr !== 64'd32) begin
            $display("FAIL blt_not_taken got=%h want=20", instr_addr);
            bad++;
        end
        total++;
        run_to(11);
        if (instr_addr !== 64'd52) begin
            $display("FAIL blt_taken got=%h want=34", instr_addr);
            bad++;
        end
        total++;
        exp_v = {64'hFFFF_FFFF_FFFF_FFFE, 5'd4, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL subs_neg got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(13);
        exp_v = {64'd7, 5'd5, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL blt_slot got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(14);
        exp_v = {64'd9, 5'd6, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL blt_target got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
    endtask

    task automatic test_branch();
        clear_prog();
        imem[2] = e_b(1'b0, 4);
        imem[3] = e_addi(7, 31, 3);
        imem[4] = e_addi(8, 31, 1);
        imem[5] = e_addi(8, 31, 1);
        imem[6] = e_addi(9, 31, 2);
        do_reset();
        run_to(2);
        if (instr_addr !== 64'd8) begin
            $display("FAIL b_addr0 got=%h want=8", instr_addr);
            bad++;
        end
        total++;
        run_to(3);
        if (instr_addr !== 64'd12) begin
            $display("FAIL b_addr1 got=%h want=c", instr_addr);
            bad++;
        end
        total++;
        run_to(4);
        if (instr_addr !== 64'd24) begin
            $display("FAIL b_addr2 got=%h want=18", instr_addr);
            bad++;
        end
        total++;
        run_to(5);
        exp_v = {64'd0, 5'd0, 3'b000};
        if (ex_v !== exp_v) begin
            $display("FAIL b_nowrite got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(6);
        exp_v = {64'd3, 5'd7, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL b_slot got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(7);
        exp_v = {64'd2, 5'd9, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL b_target got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
    endtask

    task automatic test_bl_br();
        clear_prog();
        imem[8]  = e_b(1'b1, 4);
        imem[9]  = e_addi(10, 31, 1);
        imem[13] = e_br(30);
        imem[14] = e_addi(11, 31, 4);
        do_reset();
        run_to(10);
        if (instr_addr !== 64'h30) begin
            $display("FAIL bl_target got=%h want=30", instr_addr);
            bad++;
        end
        total++;
        run_to(11);
        exp_v = {64'h24, 5'd30, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL bl_link got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(12);
        if (instr_addr !== 64'h38) begin
            $display("FAIL br_slot_addr got=%h want=38", instr_addr);
            bad++;
        end
        total++;
        run_to(13);
        if (instr_addr !== 64'h24) begin
            $display("FAIL br_return got=%h want=24", instr_addr);
            bad++;
        end
        total++;
        run_to(15);
        exp_v = {64'd4, 5'd11, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL br_slot got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        run_to(16);
        exp_v = {64'd1, 5'd10, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL br_landed got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
    endtask

    task automatic test_mem_cbz();
        logic [130:0] st_v;
        logic [130:0] st_exp;
        clear_prog();
        imem[0] = e_addi(1, 31, 5);
        imem[3] = e_mem(1'b0, 1, 31, -8);
        imem[4] = e_cbz(31, 3);
        imem[5] = e_mem(1'b1, 2, 1, 16);
        imem[6] = e_addi(8, 31, 1);
        imem[7] = e_cbz(1, 4);
        imem[8] = e_addi(12, 31, 6);
        do_reset();
        run_to(6);
        st_v   = {ex_result, ex_store_data, ex_reg_write, ex_mem_read, ex_mem_write};
        st_exp = {64'hFFFF_FFFF_FFFF_FFF8, 64'd5, 3'b001};
        if (st_v !== st_exp) begin
            $display("FAIL stur got=%h want=%h", st_v, st_exp);
            bad++;
        end
        total++;
        if (instr_addr !== 64'd28) begin
            $display("FAIL cbz_taken got=%h want=1c", instr_addr);
            bad++;
        end
        total++;
        run_to(8);
        exp_v = {64'd21, 5'd2, 3'b110};
        if (ex_v !== exp_v) begin
            $display("FAIL ldur got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
        if (instr_addr !== 64'd36) begin
            $display("FAIL cbz_not_taken got=%h want=24", instr_addr);
            bad++;
        end
        total++;
        run_to(10);
        exp_v = {64'd6, 5'd12, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL cbz_fall got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
    endtask

    task automatic test_midrun_reset();
        run_to(5);
        do_reset();
        if (instr_addr !== 64'd0) begin
            $display("FAIL mid_addr got=%h want=0", instr_addr);
            bad++;
        end
        total++;
        run_to(2);
        if (ex_v !== 72'd0) begin
            $display("FAIL mid_squash got=%h want=0", ex_v);
            bad++;
        end
        total++;
        run_to(3);
        exp_v = {64'd5, 5'd1, 3'b100};
        if (ex_v !== exp_v) begin
            $display("FAIL mid_restart got=%h want=%h", ex_v, exp_v);
            bad++;
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_flags();
        test_branch();
        test_bl_br();
        test_mem_cbz();
        test_midrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
